gen_register: RTL and testbench

GEN_REGISTER -- requirements
Module: gen_register

---
 rtl/gen_register.sv | 70 +++++++
 tb/tb_gen_register.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/gen_register.sv
// gen_register
//   Holds a WIDTH-bit register that is written from an interface strobed by
//   WCLK. WCLK is asynchronous to clk. WE and WDATA are quasi-static: the
//   writer keeps them stable around each WCLK rise, so only WCLK is
//   synchronized. Each detected WCLK rising edge that sees WE=1 loads WDATA
//   into GEN_OUT. GEN_UPD then pulses for exactly one clk cycle.
//
//   Ports
//     clk     in   system clock; all state changes on its rising edge
//     rst_n   in   asynchronous active-low reset (released synchronously)
//     WE      in   write enable, sampled at the clk edge where a rise is seen
//     WDATA   in   [WIDTH-1:0] write data, sampled at that same edge
//     WCLK    in   asynchronous write strobe, rising edge triggers a write
//     GEN_OUT out  [WIDTH-1:0] stored value, straight from a flop
//     GEN_UPD out  one-cycle pulse, high in the cycle after GEN_OUT loads
//
//   SYNC_STAGES must be 2 or 3.
module gen_register #(
   parameter int unsigned           WIDTH       = 16,
   parameter logic [WIDTH-1:0]      RESET_VAL   = '0,
   parameter int unsigned           SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             WE,
   input  logic [WIDTH-1:0] WDATA,
   input  logic             WCLK,
   output logic [WIDTH-1:0] GEN_OUT,
   output logic             GEN_UPD
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic [WIDTH-1:0]       gen_out_q, gen_out_d;
   logic                   gen_upd_q, gen_upd_d;
   logic                   rise;
   logic                   load;

   // Edge detect sits on the last synchronizer stage. The history flop is
   // cleared by reset, so a WCLK that is already high at reset release still
   // produces exactly one rise.
   assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign load = rise & WE;

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], WCLK};
      hist_d    = sync_q[SYNC_STAGES-1];
      gen_out_d = gen_out_q;
      gen_upd_d = load;
      if (load) gen_out_d = WDATA;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         hist_q    <= 1'b0;
         gen_out_q <= RESET_VAL;
         gen_upd_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         hist_q    <= hist_d;
         gen_out_q <= gen_out_d;
         gen_upd_q <= gen_upd_d;
      end
   end

   assign GEN_OUT = gen_out_q;
   assign GEN_UPD = gen_upd_q;

endmodule

// File: tb/tb_gen_register.sv
module tb_gen_register;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        WE;
   logic [15:0] WDATA;
   logic        WCLK;
   logic [15:0] GEN_OUT;
   logic        GEN_UPD;

   int n_run  = 0;
   int n_fail = 0;
   int upd_cnt  = 0;
   int long_cnt = 0;
   logic upd_prev = 1'b0;
   int base;

   gen_register #(.WIDTH(16), .RESET_VAL(16'h0000), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .WE      (WE),
      .WDATA   (WDATA),
      .WCLK    (WCLK),
      .GEN_OUT (GEN_OUT),
      .GEN_UPD (GEN_UPD)
   );

   always #5 clk = ~clk;

   // Count GEN_UPD pulses and any pulse that lasts more than one cycle.
   always @(negedge clk) begin
      if (GEN_UPD) upd_cnt <= upd_cnt + 1;
      if (GEN_UPD && upd_prev) long_cnt <= long_cnt + 1;
      upd_prev <= GEN_UPD;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0; WE = 1'b1; WDATA = 16'hFFFF; WCLK = 1'b0;

      // Reset held: outputs pinned while WCLK toggles with WE=1.
      for (int i = 0; i < 6; i++) begin
         WCLK = ~WCLK;
         tick();
         chk("rst_out", GEN_OUT, 16'h0000);
         chk("rst_upd", GEN_UPD, 0);
      end
      WCLK = 1'b0;
      tick();
      rst_n = 1'b1;
      tick(4);
      chk("post_rst_out", GEN_OUT, 16'h0000);

      // Basic write with exact latency: sampled at N, detected N+1, load N+2.
      WE = 1'b1; WDATA = 16'hA3A3;
      tick(2);
      base = upd_cnt;
      WCLK = 1'b1;
      tick();                                // edge N
      chk("basic_n", GEN_OUT, 16'h0000);
      tick();                                // edge N+1
      chk("basic_n1", GEN_OUT, 16'h0000);
      tick();                                // edge N+2
      chk("basic_n2_out", GEN_OUT, 16'hA3A3);
      chk("basic_n2_upd", GEN_UPD, 1);
      tick();
      chk("basic_n3_upd", GEN_UPD, 0);
      tick(2);
      WCLK = 1'b0;
      tick(4);
      chk("basic_pulses", upd_cnt - base, 1);

      // Write blocked by WE=0.
      WE = 1'b0; WDATA = 16'h5A5A;
      tick(4);
      base = upd_cnt;
      WCLK = 1'b1;
      tick(6);
      WCLK = 1'b0;
      tick(4);
      chk("blocked_out", GEN_OUT, 16'hA3A3);
      chk("blocked_pulses", upd_cnt - base, 0);

      // Back-to-back pulses, each phase 4 cycles.
      WE = 1'b1; WDATA = 16'h1234;
      tick(4);
      base = upd_cnt;
      WCLK = 1'b1;
      tick(4);
      chk("b2b_first", GEN_OUT, 16'h1234);
      WCLK = 1'b0; WDATA = 16'hBEEF;
      tick(4);
      WCLK = 1'b1;
      tick(4);
      WCLK = 1'b0;
      tick(4);
      chk("b2b_out", GEN_OUT, 16'hBEEF);
      chk("b2b_pulses", upd_cnt - base, 2);

      // Level then fall; the rise rewrites the same value and still pulses,
      // the WDATA change while high must not land.
      base = upd_cnt;
      WCLK = 1'b1;
      tick(10);
      WDATA = 16'h0F0F;
      tick(10);
      chk("level_out", GEN_OUT, 16'hBEEF);
      WCLK = 1'b0;
      tick(6);
      chk("fall_out", GEN_OUT, 16'hBEEF);
      chk("level_pulses", upd_cnt - base, 1);

      // Reset mid-sync with WCLK held high: cleared immediately, then one
      // write after release because the history flop restarts at 0.
      WDATA = 16'h0F0F; WE = 1'b1;
      tick(4);
      WCLK = 1'b1;
      tick();                                // rise sampled
      rst_n = 1'b0;
      #1;
      chk("midrst_async_out", GEN_OUT, 16'h0000);
      tick();
      chk("midrst_out", GEN_OUT, 16'h0000);
      chk("midrst_upd", GEN_UPD, 0);
      rst_n = 1'b1;
      base = upd_cnt;
      tick(2);                               // R1, R2: detected only
      chk("midrst_r2_out", GEN_OUT, 16'h0000);
      tick();                                // R3: load
      chk("midrst_r3_out", GEN_OUT, 16'h0F0F);
      chk("midrst_r3_upd", GEN_UPD, 1);
      tick(6);
      WCLK = 1'b0;
      tick(4);
      chk("midrst_pulses", upd_cnt - base, 1);
      chk("midrst_final", GEN_OUT, 16'h0F0F);

      chk("pulse_width", long_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
